// File: rtl/execute_cross4_node_mix_reduce_if.sv
// ---------------------------------------------------------------------------
// execute_cross4_node_mix_reduce_if
//
// Purpose: bundles the controller handshake and the two read ports of the
// 32-entry node-mix array used by execute_cross4_node_mix_reduce.
//
// Signals:
//   ap_start, num_words             controller -> block (start request, length)
//   ap_idle, ap_ready, ap_done      block -> controller handshake
//   sum_out                         block -> controller signed result
//   max_out                         block -> controller signed maximum
//                                   (present only with MIX_REDUCE_MAX_EN)
//   address0/ce0, address1/ce1      block -> array read ports (even / odd)
//   q0, q1                          array -> block read data
//
// Modports:
//   slave  - the reduce block
//   master - the surrounding controller / array side
//
// Optional feature macro: MIX_REDUCE_MAX_EN
// ---------------------------------------------------------------------------
interface execute_cross4_node_mix_reduce_if #(
   parameter int DataWidth    = 32,
   parameter int AddressWidth = 5,
   parameter int AccWidth     = 40
);
   logic                    ap_start;
   logic [AddressWidth:0]   num_words;
   logic                    ap_idle;
   logic                    ap_ready;
   logic                    ap_done;
   logic [AddressWidth-1:0] address0;
   logic                    ce0;
   logic [DataWidth-1:0]    q0;
   logic [AddressWidth-1:0] address1;
   logic                    ce1;
   logic [DataWidth-1:0]    q1;
   logic [AccWidth-1:0]     sum_out;
`ifdef MIX_REDUCE_MAX_EN
   logic [DataWidth-1:0]    max_out;

   modport slave (
      input  ap_start, num_words, q0, q1,
      output ap_idle, ap_ready, ap_done, address0, ce0, address1, ce1,
             sum_out, max_out
   );
   modport master (
      output ap_start, num_words, q0, q1,
      input  ap_idle, ap_ready, ap_done, address0, ce0, address1, ce1,
             sum_out, max_out
   );
`else
   modport slave (
      input  ap_start, num_words, q0, q1,
      output ap_idle, ap_ready, ap_done, address0, ce0, address1, ce1,
             sum_out
   );
   modport master (
      output ap_start, num_words, q0, q1,
      input  ap_idle, ap_ready, ap_done, address0, ce0, address1, ce1,
             sum_out
   );
`endif
endinterface

// File: rtl/execute_cross4_node_mix_reduce.sv
// ---------------------------------------------------------------------------
// execute_cross4_node_mix_reduce
//
// Purpose: on an accepted ap_start, reads the first num_words entries of the
// node-mix array (clamped to AddressRange) two per cycle -- even entries on
// port 0, odd entries on port 1 -- and returns their signed, wrapping sum on
// sum_out with an ap_start/ap_ready/ap_done handshake.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (0 = reset)
//   bus    execute_cross4_node_mix_reduce_if.slave: handshake, num_words,
//          both array read ports, sum_out (and max_out when enabled)
//
// Optional feature macro: MIX_REDUCE_MAX_EN -- adds max_out, the signed
// maximum of the words read in the run (most negative value for len=0).
// ---------------------------------------------------------------------------
module execute_cross4_node_mix_reduce #(
   parameter int DataWidth    = 32,
   parameter int AddressRange = 32,
   parameter int AddressWidth = 5,
   parameter int AccWidth     = 40
) (
   input  logic clk,
   input  logic reset,
   execute_cross4_node_mix_reduce_if.slave bus
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   localparam logic [AddressWidth:0] RANGE_LEN = (AddressWidth+1)'(AddressRange);

   state_t                  state_reg, state_next;
   logic [AddressWidth:0]   len_reg, len_next;
   logic [AddressWidth-1:0] k_reg, k_next;
   logic [AccWidth-1:0]     acc_reg, acc_next;
   logic [AccWidth-1:0]     sum_reg, sum_next;
   logic                    v0_reg, v1_reg;

   logic [AddressWidth:0]   clamped_len;
   logic [AddressWidth:0]   pair_base;   // 2k, one bit wider than an address
   logic [AddressWidth:0]   pair_odd;    // 2k+1
   logic [AccWidth-1:0]     q0_ext, q1_ext, acc_sum;

   logic                    ap_idle_c, ap_ready_c, ap_done_c;
   logic                    ce0_c, ce1_c;
   logic [AddressWidth-1:0] address0_c, address1_c;
   logic                    start_c;     // start accepted this cycle

   assign clamped_len = (bus.num_words > RANGE_LEN) ? RANGE_LEN : bus.num_words;
   assign pair_base   = {k_reg, 1'b0};
   assign pair_odd    = {k_reg, 1'b1};

   // Read data belongs to the issue of the previous cycle; v0/v1 remember
   // whether that issue actually enabled each port.
   assign q0_ext  = {{(AccWidth-DataWidth){bus.q0[DataWidth-1]}}, bus.q0};
   assign q1_ext  = {{(AccWidth-DataWidth){bus.q1[DataWidth-1]}}, bus.q1};
   assign acc_sum = acc_reg + (v0_reg ? q0_ext : '0) + (v1_reg ? q1_ext : '0);

   always_comb begin
      state_next = state_reg;
      len_next   = len_reg;
      k_next     = k_reg;
      acc_next   = acc_reg;
      sum_next   = sum_reg;
      ap_idle_c  = 1'b0;
      ap_ready_c = 1'b0;
      ap_done_c  = 1'b0;
      ce0_c      = 1'b0;
      ce1_c      = 1'b0;
      address0_c = '0;
      address1_c = '0;
      start_c    = 1'b0;
      case (state_reg)
         IDLE: begin
            ap_idle_c = 1'b1;
            if (bus.ap_start) begin
               ap_ready_c = 1'b1;
               start_c    = 1'b1;
               len_next   = clamped_len;
               k_next     = '0;
               acc_next   = '0;
               if (clamped_len == '0) begin
                  sum_next   = '0;
                  state_next = DONE;
               end else begin
                  state_next = READ;
               end
            end
         end
         READ: begin
            ce0_c      = 1'b1;
            address0_c = pair_base[AddressWidth-1:0];
            address1_c = pair_odd[AddressWidth-1:0];
            ce1_c      = (pair_odd < len_reg);
            k_next     = k_reg + 1'b1;
            acc_next   = acc_sum;
            // Last pair is the one whose even index reaches len-1 or len-2.
            if ((pair_base + (AddressWidth+1)'(2)) >= len_reg)
               state_next = DRAIN;
         end
         DRAIN: begin
            // The final beat lands this cycle; fold it straight into the result.
            acc_next   = acc_sum;
            sum_next   = acc_sum;
            state_next = DONE;
         end
         DONE: begin
            ap_done_c  = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         len_reg   <= '0;
         k_reg     <= '0;
         acc_reg   <= '0;
         sum_reg   <= '0;
         v0_reg    <= 1'b0;
         v1_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         len_reg   <= len_next;
         k_reg     <= k_next;
         acc_reg   <= acc_next;
         sum_reg   <= sum_next;
         v0_reg    <= ce0_c;
         v1_reg    <= ce1_c;
      end
   end

   assign bus.ap_idle  = ap_idle_c;
   assign bus.ap_ready = ap_ready_c;
   assign bus.ap_done  = ap_done_c;
   assign bus.ce0      = ce0_c;
   assign bus.ce1      = ce1_c;
   assign bus.address0 = address0_c;
   assign bus.address1 = address1_c;
   assign bus.sum_out  = sum_reg;

`ifdef MIX_REDUCE_MAX_EN
   localparam logic [DataWidth-1:0] MOST_NEG = {1'b1, {(DataWidth-1){1'b0}}};

   logic [DataWidth-1:0] max_reg, max_next;
   logic [DataWidth-1:0] max_out_reg, max_out_next;
   logic [DataWidth-1:0] max_cand;

   // Running maximum including the beat arriving this cycle.
   always_comb begin
      max_cand = max_reg;
      if (v0_reg && ($signed(bus.q0) > $signed(max_cand)))
         max_cand = bus.q0;
      if (v1_reg && ($signed(bus.q1) > $signed(max_cand)))
         max_cand = bus.q1;
   end

   always_comb begin
      max_next     = max_reg;
      max_out_next = max_out_reg;
      if (start_c) begin
         max_next = MOST_NEG;
         if (clamped_len == '0)
            max_out_next = MOST_NEG;
      end else if (state_reg == READ) begin
         max_next = max_cand;
      end else if (state_reg == DRAIN) begin
         max_next     = max_cand;
         max_out_next = max_cand;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         max_reg     <= '0;
         max_out_reg <= '0;
      end else begin
         max_reg     <= max_next;
         max_out_reg <= max_out_next;
      end
   end

   assign bus.max_out = max_out_reg;
`endif

endmodule

// File: tb/tb_execute_cross4_node_mix_reduce.sv
// ---------------------------------------------------------------------------
// tb_execute_cross4_node_mix_reduce
//
// Bench for execute_cross4_node_mix_reduce: a behavioural array model answers
// both read ports, a reference model computes the expected sum (and maximum
// when MIX_REDUCE_MAX_EN is defined) straight from the array contents, and a
// monitor checks issue addresses, enables, latency and results every cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_execute_cross4_node_mix_reduce;

   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int ACC = 40;

   logic clk = 1'b0;
   logic reset;

   execute_cross4_node_mix_reduce_if #(.DataWidth(DW), .AddressWidth(AW), .AccWidth(ACC)) bus ();

   execute_cross4_node_mix_reduce #(
      .DataWidth(DW), .AddressRange(32), .AddressWidth(AW), .AccWidth(ACC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [0:31];
   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Array model: one-cycle read latency; garbage when a port is not enabled
   // so that masking mistakes show up in the sum.
   always @(posedge clk) begin
      if (bus.ce0) bus.q0 <= mem[bus.address0];
      else         bus.q0 <= $urandom;
      if (bus.ce1) bus.q1 <= mem[bus.address1];
      else         bus.q1 <= $urandom;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [ACC-1:0] model_sum(input int len);
      longint s = 0;
      for (int i = 0; i < len; i++) s += longint'($signed(mem[i]));
      return s[ACC-1:0];
   endfunction

   function automatic logic [DW-1:0] model_max(input int len);
      int m = 32'h80000000;
      for (int i = 0; i < len; i++)
         if ($signed(mem[i]) > m) m = $signed(mem[i]);
      return m;
   endfunction

   // Monitor state
   bit              run_active = 0;
   int              exp_len, issue_cnt, start_cyc;
   logic [ACC-1:0]  exp_sum;
   logic [DW-1:0]   exp_max;
   int              ready_cnt = 0;
   int              done_cnt = 0;

   always @(negedge clk) begin
      if (!reset) begin
         run_active = 0;
      end else begin
         if (bus.ce0 || bus.ce1) begin
            chk("ce_outside_run", run_active, 1'b1);
            if (run_active) begin
               chk("issue_in_range", issue_cnt < (exp_len + 1) / 2, 1'b1);
               chk("ce0", bus.ce0, 1'b1);
               chk("address0", bus.address0, 2 * issue_cnt);
               chk("address1", bus.address1, 2 * issue_cnt + 1);
               chk("ce1", bus.ce1, (2 * issue_cnt + 1) < exp_len);
               issue_cnt++;
            end
         end
         if (bus.ap_ready) begin
            chk("ready_while_busy", run_active, 1'b0);
            chk("idle_at_ready", bus.ap_idle, 1'b1);
            ready_cnt++;
            run_active = 1;
            exp_len    = (bus.num_words > 32) ? 32 : int'(bus.num_words);
            exp_sum    = model_sum(exp_len);
            exp_max    = model_max(exp_len);
            issue_cnt  = 0;
            start_cyc  = cyc;
         end
         if (bus.ap_done) begin
            done_cnt++;
            chk("done_in_run", run_active, 1'b1);
            chk("idle_at_done", bus.ap_idle, 1'b0);
            chk("latency", cyc - start_cyc, (exp_len == 0) ? 1 : (exp_len + 1) / 2 + 2);
            chk("issue_count", issue_cnt, (exp_len + 1) / 2);
            chk("sum_out", bus.sum_out, exp_sum);
`ifdef MIX_REDUCE_MAX_EN
            chk("max_out", bus.max_out, exp_max);
`endif
            $display("run len=%0d sum_out=%0h latency=%0d", exp_len, bus.sum_out, cyc - start_cyc);
            run_active = 0;
         end
      end
   end

   task automatic wait_done(input int target);
      for (int i = 0; i < 200 && done_cnt < target; i++) @(negedge clk);
      chk("done_timeout", done_cnt >= target, 1'b1);
   endtask

   task automatic run(input int n);
      int d0;
      d0 = done_cnt;
      @(posedge clk); #1;
      bus.num_words = n[AW:0];
      bus.ap_start  = 1'b1;
      @(posedge clk); #1;
      bus.ap_start  = 1'b0;
      wait_done(d0 + 1);
      @(posedge clk); #1;
   endtask

   initial begin
      int d0, r0, seen;
      reset         = 1'b0;
      bus.ap_start  = 1'b0;
      bus.num_words = '0;
      bus.q0        = '0;
      bus.q1        = '0;
      for (int i = 0; i < 32; i++) mem[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_idle",  bus.ap_idle,  1'b1);
      chk("rst_ready", bus.ap_ready, 1'b0);
      chk("rst_done",  bus.ap_done,  1'b0);
      chk("rst_ce",    {bus.ce0, bus.ce1}, 2'b00);
      chk("rst_addr",  {bus.address0, bus.address1}, '0);
      chk("rst_sum",   bus.sum_out, '0);
`ifdef MIX_REDUCE_MAX_EN
      chk("rst_max",   bus.max_out, '0);
`endif
      reset = 1'b1;

      // Full array, entry i = i
      for (int i = 0; i < 32; i++) mem[i] = i;
      run(32);
      chk("lit_sum_496", bus.sum_out, 40'd496);

      // Odd length with mixed signs
      mem[0] = 10; mem[1] = -3; mem[2] = 7; mem[3] = 100; mem[4] = -1;
      run(5);
      chk("lit_sum_113", bus.sum_out, 40'd113);

      // Zero length
      run(0);
      chk("lit_sum_len0", bus.sum_out, 40'd0);
`ifdef MIX_REDUCE_MAX_EN
      chk("lit_max_len0", bus.max_out, 32'h80000000);
`endif

      // Clamping: 40 behaves as 32
      for (int i = 0; i < 32; i++) mem[i] = i * 3 - 7;
      run(40);
      chk("lit_sum_clamp40", bus.sum_out, 40'd1264);
      run(32);
      chk("lit_sum_32_same", bus.sum_out, 40'd1264);

      // Extremes
      for (int i = 0; i < 32; i++) mem[i] = 32'h7FFFFFFF;
      run(32);
      chk("lit_sum_maxpos", bus.sum_out, 40'h0FFFFFFFE0);
      for (int i = 0; i < 32; i++) mem[i] = 32'h80000000;
      run(32);
      chk("lit_sum_maxneg", bus.sum_out, 40'hF000000000);

      // Reset in the second READ cycle
      for (int i = 0; i < 32; i++) mem[i] = i;
      d0 = done_cnt;
      @(posedge clk); #1;
      bus.num_words = 6'd32;
      bus.ap_start  = 1'b1;
      @(posedge clk); #1;            // first READ cycle
      bus.ap_start  = 1'b0;
      @(posedge clk); #1;            // second READ cycle
      reset = 1'b0;
      #1;
      chk("midrst_ce",   {bus.ce0, bus.ce1}, 2'b00);
      chk("midrst_sum",  bus.sum_out, '0);
      chk("midrst_idle", bus.ap_idle, 1'b1);
      chk("midrst_done", bus.ap_done, 1'b0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (25) @(posedge clk);
      chk("midrst_no_done", done_cnt, d0);
      run(7);
      chk("lit_sum_after_rst", bus.sum_out, 40'd21);

      // ap_start pulsed during READ is ignored
      d0 = done_cnt; r0 = ready_cnt;
      @(posedge clk); #1;
      bus.num_words = 6'd32;
      bus.ap_start  = 1'b1;
      @(posedge clk); #1;
      bus.ap_start  = 1'b0;
      repeat (2) @(posedge clk);
      #1 bus.ap_start = 1'b1;
      @(posedge clk); #1;
      bus.ap_start = 1'b0;
      wait_done(d0 + 1);
      repeat (8) @(posedge clk);
      chk("busy_start_ready", ready_cnt, r0 + 1);
      chk("busy_start_done",  done_cnt, d0 + 1);
      chk("lit_sum_busy", bus.sum_out, 40'd496);

      // ap_start held through DONE is accepted again next IDLE
      d0 = done_cnt; r0 = ready_cnt; seen = 0;
      @(posedge clk); #1;
      bus.num_words = 6'd4;
      bus.ap_start  = 1'b1;
      for (int i = 0; i < 50 && seen < 2; i++) begin
         @(negedge clk);
         if (bus.ap_ready) seen++;
      end
      @(posedge clk); #1;
      bus.ap_start = 1'b0;
      wait_done(d0 + 2);
      repeat (4) @(posedge clk);
      chk("held_start_ready", ready_cnt, r0 + 2);
      chk("held_start_done",  done_cnt, d0 + 2);
      chk("lit_sum_held", bus.sum_out, 40'd6);

`ifdef MIX_REDUCE_MAX_EN
      mem[0] = -5; mem[1] = -2; mem[2] = -9; mem[3] = -7;
      run(4);
      chk("lit_max_neg", bus.max_out, 32'hFFFFFFFE);
      chk("lit_sum_neg", bus.sum_out, 40'hFFFFFFFFE9);
      run(0);
      chk("lit_max_len0b", bus.max_out, 32'h80000000);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/execute_cross4_node_mix_reduce.md
Name: execute_cross4_node_mix_reduce

Overview:
Downstream consumer of the 32-entry node-mix array in the cross4 execute stage. On start it reads the first num_words entries through both RAM ports (two words per cycle) and accumulates their signed sum. It returns the result with an ap_start/ap_done handshake to the cross4 controller.

Parameters:
DataWidth, 32, array word width (signed two's complement)
AddressRange, 32, array depth; num_words above this is clamped to it
AddressWidth, 5, array address width
AccWidth, 40, accumulator/result width; must be at least DataWidth+AddressWidth

Ports:
clk  input  1  clock; all logic is on the rising edge
reset  input  1  asynchronous active-low reset (0 = reset)
ap_start  input  1  start request; sampled only in IDLE
num_words  input  AddressWidth+1  number of entries to sum; latched when start is accepted
ap_idle  output  1  high in IDLE
ap_ready  output  1  one-cycle pulse in the cycle start is accepted
ap_done  output  1  one-cycle pulse in DONE
address0  output  AddressWidth  array port 0 read address (even entries)
ce0  output  1  array port 0 enable
q0  input  DataWidth  array port 0 read data, valid 1 cycle after ce0
address1  output  AddressWidth  array port 1 read address (odd entries)
ce1  output  1  array port 1 enable
q1  input  DataWidth  array port 1 read data, valid 1 cycle after ce1
sum_out  output  AccWidth  signed sum; held stable from DONE until the next accepted start

Behaviour:
- Reset (asynchronous, while reset=0): state=IDLE, ap_idle=1, ap_ready=0, ap_done=0, ce0=ce1=0, addresses=0, sum_out=0, accumulator=0, pipeline valid bits=0.
- States: IDLE, READ, DRAIN, DONE.
- IDLE: ap_start=1 -> pulse ap_ready, latch len=min(num_words, AddressRange), clear the accumulator, reset the pair index k to 0.
  - If len=0, go to DONE (sum_out=0).
  - Otherwise go to READ.
- READ: each cycle drives address0=2k, ce0=1, address1=2k+1, ce1=(2k+1<len), then k++.
  - ce0 and ce1 are also registered into valid bits v0 and v1 for the next cycle.
  - After the issue with k=ceil(len/2)-1, go to DRAIN.
- Accumulate, in every cycle after an issue: acc += (v0 ? sext(q0) : 0) + (v1 ? sext(q1) : 0). Sign-extend each word to AccWidth; wrap modulo 2^AccWidth (no saturation).
- DRAIN: ce0=ce1=0. Absorbs the final read beat, then goes to DONE.
- DONE: sum_out<=acc is registered at DONE entry and is visible while ap_done=1. ap_done pulses for exactly one cycle, then the block returns to IDLE.
- Latency: for len>0, ap_done asserts ceil(len/2)+2 cycles after the ap_ready cycle. For len=0 it asserts 1 cycle after.
- ap_idle=0 in every state except IDLE.
- ap_start while not in IDLE is ignored and not queued. ap_start held high through DONE is accepted again in the next IDLE cycle.
- Odd len: the final issue has ce1=0, so q1 is never added.
- Maximum len=32: address1 reaches 31 with no address wrap.
- The block never writes the array; it has no we/d ports.
- Reset asserted mid-READ/DRAIN: enables drop immediately, sum_out returns to 0, no ap_done is produced.

Optional Feature:
MIX_REDUCE_MAX_EN
- Defined: adds output max_out (DataWidth, signed). max_out tracks the signed maximum of all valid words read in a run, using the same v0/v1 masking as the sum.
  - It is initialised to the most negative value at start acceptance and updated in the same cycles as the accumulator.
  - It is registered alongside sum_out at DONE.
  - len=0 gives 0x80000000. Reset value is 0.
- Not defined: the max_out port and its logic are absent; all other behaviour is identical.

Test Plan:
- Array preloaded with entry i = i; start with num_words=32 -> sum_out=496; ap_done exactly 18 cycles after ap_ready; ce1 never high with address1>31.
- num_words=5, entries 0..4 = 10,-3,7,100,-1 -> sum_out=113; 3 issue cycles; the last issue has ce1=0 and address0=4; ap_done 5 cycles after ap_ready.
- num_words=0 -> ce0/ce1 never asserted; sum_out=0; ap_done 1 cycle after ap_ready. num_words=40 -> behaves exactly as 32.
- All 32 entries 0x7FFFFFFF -> sum_out=0x0FFFFFFFE0. All entries 0x80000000 -> sum_out=0xF000000000 (40-bit sign-extended).
- Reset low in the 2nd READ cycle -> outputs return to reset values within that cycle, no ap_done. A fresh start then yields the correct sum. ap_start pulsed during READ -> ignored, only one ap_done.
- With MIX_REDUCE_MAX_EN, entries 0..3 = -5,-2,-9,-7 -> max_out=0xFFFFFFFE and sum_out=-23. num_words=0 -> max_out=0x80000000.
